// File: rtl/pcw_loader_pkg.sv
// Shared types and constants for the boot-image loader.
package pcw_loader_pkg;

  typedef enum logic [2:0] {AUTO, IDLE, FETCH, WRITE, FINISH} loader_state_e;

  localparam int DEFAULT_LENGTH = 276;
  localparam int LAT_W          = 2;

  // Cycles from FETCH entry to the done strobe, with no memory backpressure.
  function automatic int copy_cycles(input int length, input int rom_lat);
    return length * (rom_lat + 1) + 1;
  endfunction

endpackage

// File: rtl/loader_write_mux.sv
// Hands the memory write port to the host while host_dl is high, else to the loader.
// Purely combinational, so host writes reach memory in the same cycle.
module loader_write_mux #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              host_dl,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  assign wr      = host_dl ? host_wr   : ld_wr;
  assign wr_addr = host_dl ? host_addr : ld_addr;
  assign wr_data = host_dl ? host_data : ld_data;

endmodule

// File: rtl/rom_replay_loader.sv
// Copies LENGTH ROM words to DEST_BASE after reset or start, ROM_LAT+1 cycles per word, stalls on wr_wait.
// host_dl aborts a copy and owns the write port; LOADER_CHECKSUM_EN adds checksum/csum_ok.
module rom_replay_loader
  import pcw_loader_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int LENGTH    = DEFAULT_LENGTH,
  parameter int ROM_LAT   = 1,
  parameter int DEST_BASE = 0
`ifdef LOADER_CHECKSUM_EN
  , parameter logic [15:0] EXP_SUM = 16'h0
`endif
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              host_dl,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_wait,
  output logic              busy,
  output logic              done,
  output logic              aborted
`ifdef LOADER_CHECKSUM_EN
  , output logic [15:0]     checksum
  , output logic            csum_ok
`endif
);

  localparam int                IDX_W    = $clog2(LENGTH + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(LENGTH - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(ROM_LAT - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(DEST_BASE);

  loader_state_e     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [15:0]       csum_q, csum_d;
  logic              copy_go;
  logic [IDX_W-1:0]  idx_nxt;

  assign copy_go = !host_dl && ((state_q == AUTO) || (state_q == IDLE && start));
  assign idx_nxt = idx_q + IDX_W'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lat_d      = lat_q;
    rom_addr_d = rom_addr_q;
    wr_d       = wr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    aborted_d  = aborted_q;
    csum_d     = csum_q;
    if (copy_go) begin
      state_d    = FETCH;
      idx_d      = '0;
      lat_d      = '0;
      rom_addr_d = '0;
      aborted_d  = 1'b0;
      csum_d     = '0;
    end else begin
      case (state_q)
        FETCH, WRITE: begin
          if (host_dl) begin
            // Host takes the port mid-copy: drop the pending write, no done.
            state_d   = IDLE;
            wr_d      = 1'b0;
            aborted_d = 1'b1;
          end else if (state_q == FETCH) begin
            if (lat_q == LAT_LAST) begin
              state_d   = WRITE;
              wr_d      = 1'b1;
              wr_data_d = rom_data;
              wr_addr_d = BASE + ADDR_W'(idx_q);
            end else begin
              lat_d = lat_q + LAT_W'(1);
            end
          end else if (!wr_wait) begin
            wr_d   = 1'b0;
            csum_d = csum_q + 16'(wr_data_q);
            if (idx_q == IDX_LAST) begin
              state_d = FINISH;
            end else begin
              state_d    = FETCH;
              idx_d      = idx_nxt;
              lat_d      = '0;
              rom_addr_d = ADDR_W'(idx_nxt);
            end
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
    busy_d = (state_d == FETCH) || (state_d == WRITE) || (state_d == FINISH);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= AUTO;
      idx_q      <= '0;
      lat_q      <= '0;
      rom_addr_q <= '0;
      wr_q       <= 1'b0;
      wr_addr_q  <= BASE;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      rom_addr_q <= rom_addr_d;
      wr_q       <= wr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      csum_q     <= csum_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;

`ifdef LOADER_CHECKSUM_EN
  assign checksum = csum_q;
  assign csum_ok  = done_q && (csum_q == EXP_SUM);
`endif

  loader_write_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_write_mux (
    .host_dl   (host_dl),
    .host_wr   (host_wr),
    .host_addr (host_addr),
    .host_data (host_data),
    .ld_wr     (wr_q),
    .ld_addr   (wr_addr_q),
    .ld_data   (wr_data_q),
    .wr        (wr),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

endmodule

// File: tb/tb_rom_replay_loader.sv
// Directed bench: u_a copies 4 words at ROM_LAT=1, u_b copies 2 words at ROM_LAT=3 to base 0xFFFF.
// Loader address flop is the ROM's first stage, so the ROM model adds ROM_LAT-1 register stages.
module tb_rom_replay_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset_b, start, start_b;
  logic        host_dl, host_wr, wr_wait;
  logic [15:0] host_addr;
  logic [7:0]  host_data;
  logic        zero1;
  logic [15:0] zero16;
  logic [7:0]  zero8;

  logic [15:0] rom_addr_a, wr_addr_a, rom_addr_b, wr_addr_b;
  logic [7:0]  rom_data_a, wr_data_a, rom_data_b, wr_data_b;
  logic        wr_a, busy_a, done_a, aborted_a;
  logic        wr_b, busy_b, done_b, aborted_b;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum_a, checksum_b;
  logic        csum_ok_a, csum_ok_b;
  logic        csum_ok_last = 1'b0;
`endif

  logic [7:0]  rom_a [4];
  logic [7:0]  rom_b [2];
  logic [15:0] pb1, pb2;

  assign rom_data_a = (rom_addr_a < 16'd4) ? rom_a[rom_addr_a[1:0]] : 8'h00;
  always @(posedge clk) begin
    pb1 <= rom_addr_b;
    pb2 <= pb1;
  end
  assign rom_data_b = rom_b[pb2[0]];

  rom_replay_loader #(
    .ADDR_W(16), .DATA_W(8), .LENGTH(4), .ROM_LAT(1), .DEST_BASE(0)
`ifdef LOADER_CHECKSUM_EN
    , .EXP_SUM(16'h0201)
`endif
  ) u_a (
    .clk_sys(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .host_dl(host_dl), .host_wr(host_wr), .host_addr(host_addr), .host_data(host_data),
    .wr(wr_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_wait(wr_wait),
    .busy(busy_a), .done(done_a), .aborted(aborted_a)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum_a), .csum_ok(csum_ok_a)
`endif
  );

  rom_replay_loader #(
    .ADDR_W(16), .DATA_W(8), .LENGTH(2), .ROM_LAT(3), .DEST_BASE(16'hFFFF)
  ) u_b (
    .clk_sys(clk), .reset(reset_b), .start(start_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .host_dl(zero1), .host_wr(zero1), .host_addr(zero16), .host_data(zero8),
    .wr(wr_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_wait(zero1),
    .busy(busy_b), .done(done_b), .aborted(aborted_b)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum_b), .csum_ok(csum_ok_b)
`endif
  );

  int          cyc = 0;
  int          n_acc = 0, done_cnt_a = 0, done_cyc_a = 0, fetch_cyc_a = 0;
  logic        busy_prev_a = 1'b0;
  logic [15:0] acc_addr [64];
  logic [7:0]  acc_data [64];

  always @(posedge clk) cyc++;

  // Loader-side write log for u_a; host-owned cycles are not loader accepts.
  always @(negedge clk) begin
    if (busy_a === 1'b1 && busy_prev_a !== 1'b1) fetch_cyc_a = cyc;
    busy_prev_a = busy_a;
    if (done_a === 1'b1) begin
      done_cnt_a++;
      done_cyc_a = cyc;
`ifdef LOADER_CHECKSUM_EN
      csum_ok_last = csum_ok_a;
`endif
    end
    if (wr_a === 1'b1 && wr_wait === 1'b0 && host_dl === 1'b0 && n_acc < 64) begin
      acc_addr[n_acc] = wr_addr_a;
      acc_data[n_acc] = wr_data_a;
      n_acc++;
    end
  end

  int total = 0, bad = 0;
  int base_acc, base_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, input int base);
    for (int i = 0; i < budget && done_cnt_a == base; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset_b = 1'b1; start = 1'b0; start_b = 1'b0;
    host_dl = 1'b0; host_wr = 1'b0; host_addr = '0; host_data = '0; wr_wait = 1'b0;
    zero1 = 1'b0; zero16 = '0; zero8 = '0;
    rom_a[0] = 8'hA0; rom_a[1] = 8'hA1; rom_a[2] = 8'hA2; rom_a[3] = 8'hA3;
    rom_b[0] = 8'h5A; rom_b[1] = 8'hC3;
    tick(); tick();

    chk("rst_rom_addr", rom_addr_a, 0);
    chk("rst_wr", wr_a, 0);
    chk("rst_wr_addr", wr_addr_a, 0);
    chk("rst_wr_data", wr_data_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_aborted", aborted_a, 0);
    chk("rst_b_wr_addr_base", wr_addr_b, 32'hFFFF);

    // Auto copy after reset release
    base_acc = n_acc; base_done = done_cnt_a;
    reset = 1'b0;
    wait_done_a(40, base_done);
    chk("t1_done_cnt", done_cnt_a - base_done, 1);
    chk("t1_acc_cnt", n_acc - base_acc, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", acc_addr[base_acc + i], i);
      chk("t1_data", acc_data[base_acc + i], 32'hA0 + i);
    end
    chk("t1_latency", done_cyc_a - fetch_cyc_a + 1, 9);
    chk("t1_done_one_cycle", done_a, 0);
    chk("t1_busy_after", busy_a, 0);

    // ROM_LAT=3, wrapping destination base
    reset_b = 1'b0;
    tick();
    chk("t2_c1_busy", busy_b, 1);
    chk("t2_c1_rom_addr", rom_addr_b, 0);
    tick(); chk("t2_c2_rom_addr", rom_addr_b, 0); chk("t2_c2_wr", wr_b, 0);
    tick(); chk("t2_c3_rom_addr", rom_addr_b, 0); chk("t2_c3_wr", wr_b, 0);
    tick();
    chk("t2_c4_wr", wr_b, 1);
    chk("t2_c4_addr", wr_addr_b, 32'hFFFF);
    chk("t2_c4_data", wr_data_b, 32'h5A);
    tick(); chk("t2_c5_rom_addr", rom_addr_b, 1); chk("t2_c5_wr", wr_b, 0);
    tick(); chk("t2_c6_rom_addr", rom_addr_b, 1);
    tick(); chk("t2_c7_rom_addr", rom_addr_b, 1); chk("t2_c7_done", done_b, 0);
    tick();
    chk("t2_c8_wr", wr_b, 1);
    chk("t2_c8_addr_wrapped", wr_addr_b, 0);
    chk("t2_c8_data", wr_data_b, 32'hC3);
    tick(); chk("t2_c9_done", done_b, 1);
    tick(); chk("t2_c10_done", done_b, 0); chk("t2_c10_busy", busy_b, 0);

    // Backpressure on word 1
    base_acc = n_acc; base_done = done_cnt_a;
    pulse_start();
    for (int i = 0; i < 20 && !(wr_a === 1'b1 && wr_addr_a === 16'd1); i++) tick();
    chk("t3_word1_seen", wr_a, 1);
    wr_wait = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_wr", wr_a, 1);
      chk("t3_hold_addr", wr_addr_a, 1);
      chk("t3_hold_data", wr_data_a, 32'hA1);
      tick();
    end
    wr_wait = 1'b0;
    wait_done_a(40, base_done);
    chk("t3_done_cnt", done_cnt_a - base_done, 1);
    chk("t3_acc_cnt", n_acc - base_acc, 4);
    chk("t3_acc1_addr", acc_addr[base_acc + 1], 1);
    chk("t3_acc1_data", acc_data[base_acc + 1], 32'hA1);
    chk("t3_latency", done_cyc_a - fetch_cyc_a + 1, 14);

    // Host download cuts the copy during word 2
    base_acc = n_acc; base_done = done_cnt_a;
    pulse_start();
    for (int i = 0; i < 20 && !(wr_a === 1'b1 && wr_addr_a === 16'd2); i++) tick();
    chk("t4_word2_seen", wr_a, 1);
    host_dl = 1'b1; host_wr = 1'b1; host_addr = 16'h1234; host_data = 8'h77;
    #1;
    chk("t4_host_wr", wr_a, 1);
    chk("t4_host_addr", wr_addr_a, 32'h1234);
    chk("t4_host_data", wr_data_a, 32'h77);
    tick();
    chk("t4_busy_drop", busy_a, 0);
    chk("t4_aborted", aborted_a, 1);
    host_wr = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t4_start_ignored", busy_a, 0);
    host_dl = 1'b0;
    tick(); tick(); tick();
    chk("t4_start_not_queued", busy_a, 0);
    chk("t4_wr_idle", wr_a, 0);
    chk("t4_acc_cnt", n_acc - base_acc, 2);
    chk("t4_no_done", done_cnt_a - base_done, 0);
    chk("t4_aborted_sticky", aborted_a, 1);

    // Restart clears aborted
    base_acc = n_acc; base_done = done_cnt_a;
    pulse_start();
    chk("t4b_busy", busy_a, 1);
    chk("t4b_aborted_clr", aborted_a, 0);
    wait_done_a(40, base_done);
    chk("t4b_done_cnt", done_cnt_a - base_done, 1);
    chk("t4b_acc_cnt", n_acc - base_acc, 4);

    // Reset during the fetch of idx 3
    pulse_start();
    for (int i = 0; i < 20 && !(busy_a === 1'b1 && wr_a === 1'b0 && rom_addr_a === 16'd3); i++) tick();
    chk("t5_idx3_seen", rom_addr_a, 3);
    reset = 1'b1;
    tick();
    chk("t5_rst_rom_addr", rom_addr_a, 0);
    chk("t5_rst_wr", wr_a, 0);
    chk("t5_rst_wr_addr", wr_addr_a, 0);
    chk("t5_rst_wr_data", wr_data_a, 0);
    chk("t5_rst_busy", busy_a, 0);
    chk("t5_rst_done", done_a, 0);
    tick();
    base_acc = n_acc; base_done = done_cnt_a;
    reset = 1'b0;
    wait_done_a(40, base_done);
    chk("t5_done_cnt", done_cnt_a - base_done, 1);
    chk("t5_acc_cnt", n_acc - base_acc, 4);
    chk("t5_first_addr", acc_addr[base_acc], 0);
    chk("t5_first_data", acc_data[base_acc], 32'hA0);
    chk("t5_last_addr", acc_addr[base_acc + 3], 3);

`ifdef LOADER_CHECKSUM_EN
    rom_a[0] = 8'h01; rom_a[1] = 8'h02; rom_a[2] = 8'hFF; rom_a[3] = 8'hFF;
    base_done = done_cnt_a;
    tick();
    pulse_start();
    wait_done_a(40, base_done);
    chk("cs_sum", checksum_a, 32'h0201);
    chk("cs_ok_at_done", csum_ok_last, 1);
    pulse_start();
    chk("cs_cleared", checksum_a, 0);
    wait_done_a(40, done_cnt_a);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_replay_loader.md
Name: rom_replay_loader

Overview:
- Parametrised successor to the PCW boot-loader sequencer. It copies a fixed-length image from a synchronous boot ROM into system memory after every reset, or on demand, then emits a one-cycle execute strobe.
- Adds generic address and data widths, a configurable ROM read latency, a destination base address, and memory-side backpressure.
- Arbitrates against a host (HPS ioctl) download stream. It sits between hps_io/boot ROM and pcw_core's download port.

Parameters:
- ADDR_W, 16, width of ROM and destination addresses.
- DATA_W, 8, data width.
- LENGTH, 276, number of words copied; must be ≥1 and ≤2^ADDR_W.
- ROM_LAT, 1, ROM read latency in cycles; legal range 1..4.
- DEST_BASE, 0, destination address of word 0.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  re-trigger pulse; ignored unless IDLE.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  DATA_W  ROM data, valid ROM_LAT cycles after rom_addr.
- host_dl  in  1  host download active.
- host_wr  in  1  host write strobe.
- host_addr  in  ADDR_W  host write address.
- host_data  in  DATA_W  host write data.
- wr  out  1  memory write strobe.
- wr_addr  out  ADDR_W  memory write address.
- wr_data  out  DATA_W  memory write data.
- wr_wait  in  1  memory not ready; a write is accepted on a cycle with wr=1 and wr_wait=0.
- busy  out  1  copy in progress.
- done  out  1  one-cycle execute strobe after the last accepted word.
- aborted  out  1  sticky: last copy was cut short by host_dl; cleared on the next copy start.

Behaviour:
- Reset values:
  - Outputs: rom_addr=0, wr=0, wr_addr=DEST_BASE, wr_data=0, busy=0, done=0, aborted=0.
  - State: AUTO (pending start).
- States: AUTO, IDLE, FETCH, WRITE, FINISH.
- AUTO: entered by reset.
  - On the first cycle with reset=0 and host_dl=0, go to FETCH with idx=0.
  - If host_dl=1, remain in AUTO until host_dl drops.
- IDLE:
  - start=1 and host_dl=0 → FETCH, idx=0, aborted←0.
  - start while host_dl=1 is dropped; it is not queued.
- FETCH:
  - rom_addr=idx. Stays exactly ROM_LAT cycles, counted by a lat counter.
  - On the last cycle, latch rom_data into wr_data, set wr_addr=DEST_BASE+idx (modulo 2^ADDR_W), then go to WRITE.
- WRITE:
  - wr=1, held stable while wr_wait=1.
  - On accept: if idx==LENGTH-1 go to FINISH; else idx+1 and go to FETCH.
- FINISH: done=1 for exactly one cycle, then IDLE.
- busy=1 in FETCH, WRITE and FINISH; 0 in AUTO and IDLE.
- Throughput: ROM_LAT+1 cycles per word with wr_wait=0. Start to done = LENGTH·(ROM_LAT+1)+1 cycles, counting from the FETCH entry cycle.
- Host arbitration:
  - host_dl=1 in FETCH or WRITE → IDLE next cycle. aborted←1, no done pulse, and any pending write is dropped.
  - While host_dl=1: wr=host_wr, wr_addr=host_addr, wr_data=host_data, combinationally; the host owns the port.
- reset asserted mid-copy: immediate return to reset values and AUTO. The copy restarts from idx 0 after reset falls.
- idx is a $clog2(LENGTH+1)-bit counter and never wraps past LENGTH-1.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Extra output port checksum[15:0]: a modulo-2^16 sum of all words accepted by the copy, zero-extended.
  - Cleared on every copy start; held after done or abort.
  - Extra output port csum_ok = done-qualified compare against parameter EXP_SUM (default 16'h0).
- Undefined: neither port nor the adder exists, and behaviour is otherwise identical.

Decomposition:
- Package pcw_loader_pkg:
  - State enum loader_state_e {AUTO, IDLE, FETCH, WRITE, FINISH}.
  - Localparam for the default LENGTH (276).
  - A function computing cycle count from LENGTH and ROM_LAT, for the bench.
- One sub-module, loader_write_mux: a registered-free mux selecting host vs loader write signals.

Test Plan:
- LENGTH=4, ROM_LAT=1, wr_wait=0, ROM holds A0..A3; reset 1→0 → writes (0,A0),(1,A1),(2,A2),(3,A3); done high exactly at cycle 9 after FETCH entry.
- ROM_LAT=3, LENGTH=2 → each byte stays in FETCH 3 cycles; done at cycle 9; rom_addr stable during FETCH.
- wr_wait=1 for 5 cycles on word 1 → wr, wr_addr and wr_data held constant; exactly one accept per word; total latency +5.
- host_dl raised during WRITE of word 2 of 4 → no further loader writes, done stays 0, aborted=1; host_wr/addr/data appear on wr port the same cycle.
- reset pulsed while idx=3 → outputs reset the next cycle; after release the copy restarts at rom_addr 0 and completes with done.
- With LOADER_CHECKSUM_EN, bytes 01,02,FF,FF → checksum=0x0201; start pulse clears it to 0.
